// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply sequencer states, default widths
// and the MULT/MULTU encodings used by both the decoder and the sequencer.
package mips_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CW    = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } mult_state_e;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    function automatic logic is_mult(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
    endfunction

    function automatic logic is_signed_mult(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && (funct == FUNCT_MULT);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add multiply datapath: operates on operand magnitudes, keeps the
// multiplier in the low half of the accumulator and applies the sign at the end.
module mult_shift_add_dp
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               neg,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [WIDTH-1:0]   OneW  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] One2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] fixed;

    // Magnitude stays correct for the most negative value when read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sg);
        return (sg && v[WIDTH-1]) ? (~v + OneW) : v;
    endfunction

    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        shifted = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        fixed   = neg_q ? (~acc_q + One2W) : acc_q;
        product = fixed;
    end

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        if (load) begin
            acc_d   = {{WIDTH{1'b0}}, mag(op_b, signed_op)};
            mcand_d = mag(op_a, signed_op);
            neg_d   = neg;
        end else if (step) begin
            acc_d = shifted;
        end else if (fix) begin
            // Fold the sign into the accumulator so product stays stable afterwards.
            acc_d = fixed;
            neg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative multiply sequencer: FSM, iteration counter, pipeline stall/done
// generation and the HI/LO product registers.
module mult_seq_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CW    = MULT_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mult_state_e state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               load, step, fix, neg;
    logic               busy_c, stall_c, done_c;
    logic [2*WIDTH-1:0] product;

    assign neg = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        busy_c  = 1'b0;
        stall_c = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    stall_c = 1'b1;
                    count_d = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                step    = 1'b1;
                busy_c  = 1'b1;
                stall_c = 1'b1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix     = 1'b1;
                busy_c  = 1'b1;
                stall_c = 1'b1;
                state_d = DONE;
            end
            // Stall drops here so the held instruction retires as HI/LO land.
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (fix) begin
                hi_q <= product[2*WIDTH-1:WIDTH];
                lo_q <= product[WIDTH-1:0];
            end
        end
    end

    mult_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .neg      (neg),
        .signed_op(signed_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .product  (product)
    );

    assign busy  = busy_c;
    assign stall = stall_c;
    assign done  = done_c;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
